interrupt_sequencer: RTL

//  Interrupt control unit (ICU) for the 5-stage pipeline. It detects an external interrupt, waits until no

---
 rtl/interrupt_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt control unit: waits for a hazard-free pipeline, pushes the return PC and flags,
// fetches the ISR vector from data memory and loads it into the PC.
module interrupt_sequencer #(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 32,
    parameter int ADDR_W   = 20,
    parameter int VEC_ADDR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              int_req,
    input  logic              pipe_hazard,
    input  logic [PC_W-1:0]   pc_next,
    input  logic [2:0]        flags,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              int_flag,
    output logic              stall_fetch,
    output logic              flush,
    output logic              int_ack,
    output logic              stack_operation,
    output logic              push_pop,
    output logic              write_sp,
    output logic              DMW,
    output logic              DMR,
    output logic [3:0]        alu_function,
    output logic [DATA_W-1:0] push_data,
    output logic              addr_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_value
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_PUSH_HI  = 3'd2,
        S_PUSH_LO  = 3'd3,
        S_PUSH_FLG = 3'd4,
        S_RD_HI    = 3'd5,
        S_RD_LO    = 3'd6,
        S_JUMP     = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic              int_req_dly_q;
    logic              pending_q, pending_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        flg_q, flg_d;
    logic [DATA_W-1:0] vec_hi_q, vec_hi_d;
    logic              edge_s;
    logic              leave_drain_s;

    assign edge_s        = int_req & ~int_req_dly_q;
    assign leave_drain_s = (state_q == S_DRAIN) && !pipe_hazard;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pending_q) state_d = S_DRAIN; else state_d = S_IDLE;
            S_DRAIN:    if (!pipe_hazard) state_d = S_PUSH_HI; else state_d = S_DRAIN;
            S_PUSH_HI:  state_d = S_PUSH_LO;
            S_PUSH_LO:  state_d = S_PUSH_FLG;
            S_PUSH_FLG: state_d = S_RD_HI;
            S_RD_HI:    state_d = S_RD_LO;
            S_RD_LO:    state_d = S_JUMP;
            S_JUMP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath next values: a fresh edge wins over the clear on leaving DRAIN
    always_comb begin
        pc_d     = pc_q;
        flg_d    = flg_q;
        vec_hi_d = vec_hi_q;
        if (edge_s) begin
            pending_d = 1'b1;
        end else if (leave_drain_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (leave_drain_s) begin
            pc_d  = pc_next;
            flg_d = flags;
        end else begin
            pc_d  = pc_q;
            flg_d = flg_q;
        end
        if (state_q == S_RD_LO) begin
            vec_hi_d = mem_rdata;
        end else begin
            vec_hi_d = vec_hi_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_req_dly_q <= 1'b0;
            pending_q     <= 1'b0;
            pc_q          <= '0;
            flg_q         <= 3'b000;
            vec_hi_q      <= '0;
        end else begin
            int_req_dly_q <= int_req;
            pending_q     <= pending_d;
            pc_q          <= pc_d;
            flg_q         <= flg_d;
            vec_hi_q      <= vec_hi_d;
        end
    end

    // Output decode, purely from state so IDLE drives all zeros
    always_comb begin
        int_flag        = 1'b0;
        stall_fetch     = 1'b0;
        flush           = 1'b0;
        int_ack         = 1'b0;
        stack_operation = 1'b0;
        push_pop        = 1'b0;
        write_sp        = 1'b0;
        DMW             = 1'b0;
        DMR             = 1'b0;
        alu_function    = 4'b0000;
        push_data       = '0;
        addr_sel        = 1'b0;
        mem_addr        = '0;
        pc_load         = 1'b0;
        pc_value        = '0;
        case (state_q)
            S_IDLE: begin
                stall_fetch = 1'b0;
            end
            S_DRAIN: begin
                stall_fetch = 1'b1;
            end
            S_PUSH_HI, S_PUSH_LO, S_PUSH_FLG: begin
                stall_fetch     = 1'b1;
                int_flag        = 1'b1;
                stack_operation = 1'b1;
                push_pop        = 1'b1;
                write_sp        = 1'b1;
                DMW             = 1'b1;
                alu_function    = 4'b0100;
                if (state_q == S_PUSH_HI) begin
                    flush     = 1'b1;
                    int_ack   = 1'b1;
                    push_data = pc_q[PC_W-1:DATA_W];
                end else if (state_q == S_PUSH_LO) begin
                    push_data = pc_q[DATA_W-1:0];
                end else begin
                    push_data = {{(DATA_W-3){1'b0}}, flg_q};
                end
            end
            S_RD_HI, S_RD_LO: begin
                stall_fetch = 1'b1;
                int_flag    = 1'b1;
                DMR         = 1'b1;
                addr_sel    = 1'b1;
                if (state_q == S_RD_HI) begin
                    mem_addr = ADDR_W'(VEC_ADDR);
                end else begin
                    mem_addr = ADDR_W'(VEC_ADDR + 1);
                end
            end
            S_JUMP: begin
                stall_fetch = 1'b1;
                int_flag    = 1'b1;
                pc_load     = 1'b1;
                pc_value    = PC_W'({vec_hi_q, mem_rdata});
            end
            default: begin
                stall_fetch = 1'b0;
            end
        endcase
    end

endmodule
